neuron_accumulator: RTL and testbench
=====================================

// Module: neuron_accumulator
// PURPOSE
//  Consumes the product stream of the upstream multiplier and sums NUM_INPUTS products per neuron.
//  After the last product: adds the bias, rescales, applies optional ReLU, and saturates to DATA_WIDTH.
//  Emits one activation per neuron on a valid/ready output handshake.
//  Feeds the layer output buffer.
//  Backpressures the input sequencer through product_ready while an activation is being presented.
// PARAMETERS
//  DATA_WIDTH  32   width of product, bias and activation (two's complement)
//  ACC_WIDTH   48   internal accumulator width; must be >= DATA_WIDTH + $clog2(NUM_INPUTS)
//  NUM_INPUTS  784  products summed per neuron (>= 2)
//  FRAC_BITS   0    arithmetic right shift applied after bias add (fixed-point rescale)
//  RELU_EN     1    1: clamp negative results to 0; 0: pass signed result
// PORTS
//  clk            in   1                        rising-edge clock
//  reset_n        in   1                        asynchronous reset, active-low
//  clear          in   1                        synchronous abort: drop partial sum, back to ACCUM
//  product_data   in   DATA_WIDTH               signed product from multiplier
//  product_valid  in   1                        product_data valid this cycle
//  product_ready  out  1                        block accepts a product this cycle
//  bias           in   DATA_WIDTH               signed neuron bias; sampled in BIAS state
//  product_count  out  $clog2(NUM_INPUTS)       products accepted so far for current neuron
//  out_data       out  DATA_WIDTH               activation
//  out_valid      out  1                        out_data valid; held until out_ready
//  out_ready      in   1                        downstream accepts out_data
// BEHAVIOUR
//  Reset (reset_n=0, async): state=ACCUM, acc=0, product_count=0, out_data=0, out_valid=0, product_ready=1.
//  FSM states: ACCUM -> BIAS -> DONE -> ACCUM.
//  ACCUM:
//   - product_ready=1.
//   - product accepted when product_valid & product_ready: acc <= acc + sext(product_data); product_count++.
//   - Accepting the NUM_INPUTS-th product (product_count==NUM_INPUTS-1) -> BIAS; product_count wraps to 0.
//  BIAS (exactly 1 cycle):
//   - product_ready=0.
//   - s = (acc + sext(bias)) >>> FRAC_BITS.
//   - If RELU_EN and s<0: s=0.
//   - Saturate s to [-2^(DW-1), 2^(DW-1)-1].
//   - out_data <= s; out_valid <= 1; -> DONE.
//  DONE:
//   - product_ready=0; out_valid=1; out_data held stable.
//   - On out_ready=1: out_valid <= 0, acc <= 0 -> ACCUM.
//  Latency: last product accepted at cycle T -> out_valid=1 at cycle T+2.
//  Throughput: next neuron's first product accepted no earlier than the cycle after the handshake.
//  product_valid while product_ready=0: product ignored, not counted.
//   - The sequencer must hold products while product_ready=0.
//  Accumulator overflow is not detected (width rule above guarantees none for legal inputs).
//  Saturation applies only at the output stage.
//  clear=1 (any state) has priority over all other updates:
//   - acc=0, product_count=0, out_valid=0, -> ACCUM next cycle.
//   - A pending activation is discarded.
//  clear and a valid product in the same cycle: product dropped.
//  Reset mid-operation: immediate return to reset values; no partial output.
// TESTING (NUM_INPUTS=4, DATA_WIDTH=16, ACC_WIDTH=24, FRAC_BITS=0 unless stated)
//  1. Products 3,5,-2,10, bias 4, RELU_EN=1, out_ready=1
//     -> out_data=20; out_valid high exactly 1 cycle, 2 cycles after the 4th product.
//  2. Products -10,-20,5,1, bias 0, RELU_EN=1 -> out_data=0.
//     Same stimulus with RELU_EN=0 -> out_data=-24 (0xFFE8).
//  3. Products 4x 16000, bias 0 -> out_data=32767 (saturated).
//     4x -16000 with RELU_EN=0 -> out_data=-32768.
//  4. out_ready low 5 cycles after result
//     -> out_valid/out_data stable; product_ready=0; products offered meanwhile are not counted.
//  5. clear after 2 products, then products 1,1,1,1, bias 0
//     -> out_data=4; product_count back to 0 after clear.
//  6. reset_n pulsed low mid-ACCUM (count=3)
//     -> all outputs at reset values; the next 4 products yield a fresh sum.
//  FRAC_BITS=4: products 16,16,16,16, bias 0 -> out_data=4.

Source files
------------

// File: rtl/neuron_accumulator_if.sv
// ---------------------------------------------------------------------------
// neuron_accumulator_if
//   Groups the two streaming handshakes of the neuron accumulator:
//     product stream  : product_data / product_valid  ->  product_ready
//     activation out  : out_data / out_valid          <-  out_ready
//   slave  modport : the accumulator (consumes products, produces activations)
//   master modport : the environment (multiplier upstream + output buffer downstream)
// ---------------------------------------------------------------------------
interface neuron_accumulator_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] product_data;
  logic                  product_valid;
  logic                  product_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;

  modport slave (
    input  product_data,
    input  product_valid,
    input  out_ready,
    output product_ready,
    output out_data,
    output out_valid
  );

  modport master (
    output product_data,
    output product_valid,
    output out_ready,
    input  product_ready,
    input  out_data,
    input  out_valid
  );
endinterface

// File: rtl/neuron_accumulator.sv
// ---------------------------------------------------------------------------
// neuron_accumulator
//   Sums NUM_INPUTS signed products per neuron, then adds the bias, applies an
//   arithmetic right shift of FRAC_BITS, optional ReLU and saturation to
//   DATA_WIDTH, and presents one activation on a valid/ready handshake.
//   While an activation is pending the product stream is backpressured.
//
// Ports
//   clk            rising-edge clock
//   reset_n        asynchronous active-low reset
//   clear          synchronous abort: drop partial sum / pending activation
//   bias           signed neuron bias, sampled in the BIAS state
//   product_count  products accepted so far for the current neuron
//   io (slave)     product_data/valid/ready and out_data/valid/ready
// ---------------------------------------------------------------------------
module neuron_accumulator #(
  parameter int DATA_WIDTH = 32,
  parameter int ACC_WIDTH  = 48,
  parameter int NUM_INPUTS = 784,
  parameter int FRAC_BITS  = 0,
  parameter int RELU_EN    = 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          clear,
  input  logic [DATA_WIDTH-1:0]         bias,
  output logic [$clog2(NUM_INPUTS)-1:0] product_count,
  neuron_accumulator_if.slave           io
);

  localparam int CNT_W = $clog2(NUM_INPUTS);
  // One guard bit so acc + bias can never wrap before saturation.
  localparam int SUM_W = ACC_WIDTH + 1;

  localparam logic signed [SUM_W-1:0] SAT_MAX =
    {{(SUM_W - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_MIN =
    {{(SUM_W - DATA_WIDTH + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    BIAS  = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [ACC_WIDTH-1:0]   acc_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [DATA_WIDTH-1:0]  out_data_q;
  logic                   out_valid_q;

  logic                   accept;
  logic                   last_product;
  logic signed [SUM_W-1:0] biased;
  logic signed [SUM_W-1:0] shifted;
  logic signed [SUM_W-1:0] rectified;
  logic [DATA_WIDTH-1:0]  activation;

  // A product is taken only in ACCUM; clear in the same cycle drops it.
  assign accept       = (state_q == ACCUM) && io.product_valid && !clear;
  assign last_product = (cnt_q == CNT_W'(NUM_INPUTS - 1));

  assign io.product_ready = (state_q == ACCUM);
  assign io.out_data      = out_data_q;
  assign io.out_valid     = out_valid_q;
  assign product_count    = cnt_q;

  // ---------------------------------------------------------------------------
  // Output stage: bias add, rescale, optional ReLU, saturate.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    activation = '0;
    biased     = $signed({acc_q[ACC_WIDTH-1], acc_q})
               + $signed({{(SUM_W - DATA_WIDTH){bias[DATA_WIDTH-1]}}, bias});
    shifted    = biased >>> FRAC_BITS;
    rectified  = shifted;
    if ((RELU_EN != 0) && (shifted < 0)) begin
      rectified = '0;
    end
    if (rectified > SAT_MAX) begin
      activation = SAT_MAX[DATA_WIDTH-1:0];
    end else if (rectified < SAT_MIN) begin
      activation = SAT_MIN[DATA_WIDTH-1:0];
    end else begin
      activation = rectified[DATA_WIDTH-1:0];
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register + next-state logic
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: clocked state uses non-blocking assignment so every register samples pre-edge values.
    if (!reset_n) begin
      state_q <= ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ACCUM:   if (accept && last_product) state_d = BIAS;
      BIAS:    state_d = DONE;
      DONE:    if (io.out_ready) state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
    if (clear) begin
      state_d = ACCUM;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else if (clear) begin
      // out_data is left as is: with out_valid low its value is meaningless.
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        ACCUM: begin
          if (accept) begin
            acc_q <= acc_q
                   + {{(ACC_WIDTH - DATA_WIDTH){io.product_data[DATA_WIDTH-1]}}, io.product_data};
            cnt_q <= last_product ? '0 : cnt_q + 1'b1;
          end
        end
        BIAS: begin
          out_data_q  <= activation;
          out_valid_q <= 1'b1;
        end
        DONE: begin
          if (io.out_ready) begin
            out_valid_q <= 1'b0;
            acc_q       <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_accumulator.sv
// ---------------------------------------------------------------------------
// tb_neuron_accumulator
//   Three accumulators (NUM_INPUTS=4, DATA_WIDTH=16, ACC_WIDTH=24) share one
//   stimulus stream:  dut0 RELU_EN=1 FRAC_BITS=0
//                     dut1 RELU_EN=0 FRAC_BITS=0
//                     dut2 RELU_EN=1 FRAC_BITS=4
//   Expected activations come from an integer model of the neuron function.
// ---------------------------------------------------------------------------
module tb_neuron_accumulator;

  localparam int DW = 16;
  localparam int NI = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          clear = 1'b0;
  logic [DW-1:0] bias = '0;
  logic [DW-1:0] pd = '0;
  logic          pv = 1'b0;
  logic          ordy = 1'b1;

  logic [1:0]    pc [3];
  logic [DW-1:0] od [3];
  logic          ov [3];
  logic          pr [3];

  int checks   = 0;
  int failures = 0;

  const int relu_cfg [3] = '{1, 0, 1};
  const int frac_cfg [3] = '{0, 0, 4};

  always #5 clk = ~clk;

  neuron_accumulator_if #(.DATA_WIDTH(DW)) if_a ();
  neuron_accumulator_if #(.DATA_WIDTH(DW)) if_b ();
  neuron_accumulator_if #(.DATA_WIDTH(DW)) if_c ();

  assign if_a.product_data = pd;  assign if_a.product_valid = pv;  assign if_a.out_ready = ordy;
  assign if_b.product_data = pd;  assign if_b.product_valid = pv;  assign if_b.out_ready = ordy;
  assign if_c.product_data = pd;  assign if_c.product_valid = pv;  assign if_c.out_ready = ordy;

  assign od[0] = if_a.out_data;  assign ov[0] = if_a.out_valid;  assign pr[0] = if_a.product_ready;
  assign od[1] = if_b.out_data;  assign ov[1] = if_b.out_valid;  assign pr[1] = if_b.product_ready;
  assign od[2] = if_c.out_data;  assign ov[2] = if_c.out_valid;  assign pr[2] = if_c.product_ready;

  neuron_accumulator #(.DATA_WIDTH(DW), .ACC_WIDTH(24), .NUM_INPUTS(NI), .FRAC_BITS(0), .RELU_EN(1))
    u_relu (.clk(clk), .reset_n(reset_n), .clear(clear), .bias(bias), .product_count(pc[0]), .io(if_a));
  neuron_accumulator #(.DATA_WIDTH(DW), .ACC_WIDTH(24), .NUM_INPUTS(NI), .FRAC_BITS(0), .RELU_EN(0))
    u_lin  (.clk(clk), .reset_n(reset_n), .clear(clear), .bias(bias), .product_count(pc[1]), .io(if_b));
  neuron_accumulator #(.DATA_WIDTH(DW), .ACC_WIDTH(24), .NUM_INPUTS(NI), .FRAC_BITS(4), .RELU_EN(1))
    u_frac (.clk(clk), .reset_n(reset_n), .clear(clear), .bias(bias), .product_count(pc[2]), .io(if_c));

  // Neuron function in plain integer arithmetic.
  function automatic int model(input int sum, input int b, input int relu, input int frac);
    int s;
    s = (sum + b) >>> frac;
    if (relu != 0 && s < 0) s = 0;
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
    return s;
  endfunction

  function automatic int rand_product();
    return int'($urandom_range(0, 32000)) - 16000;
  endfunction

  // Drive one neuron's products and bias, then follow the activation through
  // an optional hold of `hold` cycles with out_ready low.
  task automatic run_neuron(input string name, input int p0, input int p1, input int p2,
                            input int p3, input int b, input int hold, input bit gaps);
    int p [4];
    logic [DW-1:0] exp_v [3];
    p = '{p0, p1, p2, p3};
    for (int d = 0; d < 3; d++) exp_v[d] = 16'(model(p0 + p1 + p2 + p3, b, relu_cfg[d], frac_cfg[d]));

    @(negedge clk);
    bias = 16'(b);
    ordy = (hold == 0);
    for (int i = 0; i < NI; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        pv = 1'b0;
        pd = 16'($urandom);
        @(negedge clk);
      end
      pd = 16'(p[i]);
      pv = 1'b1;
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (pr[d] !== 1'b1 || pc[d] !== 2'(i)) begin
          failures++;
          $display("FAIL %s dut%0d accum product %0d: ready=%b count=%0d, want ready=1 count=%0d",
                   name, d, i, pr[d], pc[d], i);
        end
      end
      @(negedge clk);
    end
    pv = 1'b0;

    // BIAS cycle: no result yet, input stalled.
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (ov[d] !== 1'b0 || pr[d] !== 1'b0 || pc[d] !== 2'd0) begin
        failures++;
        $display("FAIL %s dut%0d bias cycle: valid=%b ready=%b count=%0d, want 0 0 0",
                 name, d, ov[d], pr[d], pc[d]);
      end
    end
    @(negedge clk);

    // Result presented two cycles after the last product, then held.
    for (int k = 0; k <= hold; k++) begin
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (ov[d] !== 1'b1 || od[d] !== exp_v[d] || pr[d] !== 1'b0 || pc[d] !== 2'd0) begin
          failures++;
          $display("FAIL %s dut%0d result cycle %0d: valid=%b data=%0d ready=%b count=%0d, want 1 %0d 0 0",
                   name, d, k, ov[d], $signed(od[d]), pr[d], pc[d], $signed(exp_v[d]));
        end
      end
      if (k < hold) begin
        pd = 16'($urandom);
        pv = 1'b1;  // offered while stalled: must be ignored
        @(negedge clk);
      end
    end
    ordy = 1'b1;
    pv   = 1'b0;
    @(negedge clk);

    for (int d = 0; d < 3; d++) begin
      checks++;
      if (ov[d] !== 1'b0 || pr[d] !== 1'b1 || pc[d] !== 2'd0) begin
        failures++;
        $display("FAIL %s dut%0d after handshake: valid=%b ready=%b count=%0d, want 0 1 0",
                 name, d, ov[d], pr[d], pc[d]);
      end
    end
  endtask

  task automatic push(input int v);
    @(negedge clk);
    pd = 16'(v);
    pv = 1'b1;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (ov[d] !== 1'b0 || od[d] !== '0 || pr[d] !== 1'b1 || pc[d] !== 2'd0) begin
        failures++;
        $display("FAIL reset dut%0d: valid=%b data=%0d ready=%b count=%0d, want 0 0 1 0",
                 d, ov[d], od[d], pr[d], pc[d]);
      end
    end
    reset_n = 1'b1;
  endtask

  task automatic test_basic;
    run_neuron("basic", 3, 5, -2, 10, 4, 0, 1'b0);
  endtask

  task automatic test_relu;
    run_neuron("relu", -10, -20, 5, 1, 0, 0, 1'b0);
  endtask

  task automatic test_saturation;
    run_neuron("sat_pos", 16000, 16000, 16000, 16000, 0, 0, 1'b0);
    run_neuron("sat_neg", -16000, -16000, -16000, -16000, 0, 0, 1'b0);
    run_neuron("frac", 16, 16, 16, 16, 0, 0, 1'b0);
  endtask

  task automatic test_backpressure;
    run_neuron("backpressure", rand_product(), rand_product(), rand_product(),
               rand_product(), 1000, 5, 1'b0);
  endtask

  task automatic test_clear;
    push(7);
    push(9);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (pc[d] !== 2'd2) begin
        failures++;
        $display("FAIL clear_pre dut%0d count=%0d, want 2", d, pc[d]);
      end
    end
    clear = 1'b1;
    pd    = 16'd100;  // same-cycle product must be dropped
    pv    = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    pv    = 1'b0;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (pc[d] !== 2'd0 || ov[d] !== 1'b0 || pr[d] !== 1'b1) begin
        failures++;
        $display("FAIL clear dut%0d: count=%0d valid=%b ready=%b, want 0 0 1", d, pc[d], ov[d], pr[d]);
      end
    end
    run_neuron("clear_ones", 1, 1, 1, 1, 0, 0, 1'b0);

    // Clear while an activation is pending discards it.
    ordy = 1'b0;
    push(500); push(600); push(700); push(800);
    @(negedge clk);
    pv = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (ov[d] !== 1'b1) begin
        failures++;
        $display("FAIL clear_done_pre dut%0d valid=%b, want 1", d, ov[d]);
      end
    end
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    ordy  = 1'b1;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (ov[d] !== 1'b0 || pr[d] !== 1'b1 || pc[d] !== 2'd0) begin
        failures++;
        $display("FAIL clear_done dut%0d: valid=%b ready=%b count=%0d, want 0 1 0", d, ov[d], pr[d], pc[d]);
      end
    end
    run_neuron("after_clear_done", -3, 8, 2, -1, -5, 0, 1'b0);
  endtask

  task automatic test_reset_mid;
    push(1000); push(2000); push(3000);
    @(negedge clk);
    pv = 1'b0;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (pc[d] !== 2'd3) begin
        failures++;
        $display("FAIL reset_mid_pre dut%0d count=%0d, want 3", d, pc[d]);
      end
    end
    #2 reset_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (ov[d] !== 1'b0 || od[d] !== '0 || pr[d] !== 1'b1 || pc[d] !== 2'd0) begin
        failures++;
        $display("FAIL reset_mid dut%0d: valid=%b data=%0d ready=%b count=%0d, want 0 0 1 0",
                 d, ov[d], od[d], pr[d], pc[d]);
      end
    end
    @(negedge clk);
    reset_n = 1'b1;
    run_neuron("after_reset", 11, 22, 33, 44, 0, 0, 1'b0);
  endtask

  task automatic test_random;
    for (int n = 0; n < 24; n++) begin
      run_neuron("random", rand_product(), rand_product(), rand_product(), rand_product(),
                 int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 3)), 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_relu();
    test_saturation();
    test_backpressure();
    test_clear();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
